imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: streams a program image into a writable 64x32 instruction RAM.
//  Accepts a byte stream over a valid/ready link: length byte, little-endian data words, XOR checksum.
//  Drives the RAM write port and holds the CPU until a clean load completes.
//  Sits between the host/UART receive path and the instruction RAM write port.
// PARAMETERS
//  DEPTH   64   instruction words in the RAM
//  AW      6    word-address width, $clog2(DEPTH)
//  W       32   instruction word width (fixed at 4 bytes)
// PORTS
//  clk          in   1    system clock, rising edge
//  rst_n        in   1    synchronous reset, active low
//  start        in   1    one-cycle pulse to begin a load
//  rx_data      in   8    incoming byte
//  rx_valid     in   1    rx_data valid
//  rx_ready     out  1    loader accepts a byte this cycle
//  mem_we       out  1    RAM write enable, one-cycle pulse
//  mem_addr     out  AW   RAM word address (byte address = mem_addr<<2)
//  mem_wdata    out  W    RAM write data
//  cpu_hold     out  1    keep the CPU in reset while 1
//  load_done    out  1    image loaded and checksum matched
//  load_err     out  1    bad length or checksum mismatch
//  words_loaded out  AW+1 words written in the current or last load
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, cpu_hold=1. All other outputs and counters are 0.
//  Byte transfer: accepted only when rx_valid&&rx_ready at posedge. rx_ready is combinational from state.
//    rx_ready=1 only in LEN, DATA and CSUM.
//  States:
//    IDLE/DONE/ERR: start -> LEN. Entering LEN clears words_loaded, byte_cnt and csum.
//      Entering LEN sets cpu_hold=1, load_done=0, load_err=0.
//    LEN: accept byte N. N==0 or N>DEPTH -> ERR. Otherwise store N, csum=N -> DATA.
//    DATA: each accepted byte goes to lane byte_cnt; lane 0 is bits[7:0]. csum^=byte, byte_cnt++ mod 4.
//      On the 4th byte: next cycle mem_we=1, mem_wdata=assembled word, mem_addr=words_loaded.
//        words_loaded increments in that same cycle.
//      Write latency is 1 cycle after the last byte is accepted. Back-to-back bytes never stall.
//      After the Nth word is accepted -> CSUM.
//    CSUM: accept byte C. C==csum -> DONE, else -> ERR.
//      No RAM write occurs in CSUM, DONE or ERR.
//    DONE: cpu_hold=0, load_done=1. Held until the next start.
//    ERR: cpu_hold=1, load_err=1. Held until the next start.
//  start while in LEN/DATA/CSUM is ignored; the current load continues.
//  rx_valid outside LEN/DATA/CSUM: byte is not accepted (rx_ready=0) and has no effect.
//  Address never wraps: N<=DEPTH bounds mem_addr to 0..DEPTH-1.
//  Reset mid-load: abort immediately to the reset values. Words already written stay in the RAM.
//    cpu_hold=1 after a mid-load reset.
//  mem_we and mem_wdata are registered outputs. mem_addr is stable whenever mem_we=1.
// STRUCTURE
//  Package imem_pkg: typedef enum {IDLE,LEN,DATA,CSUM,DONE,ERR} ld_state_t; IMEM_DEPTH=64; IMEM_AW=6.
//  Single module, no sub-modules. Datapath: shift/lane register, 2-bit byte counter, word counter, XOR accumulator.
//  Pairs with a writable instruction RAM that has an async read port and a sync write port.
// TESTING
//  1. Reset, start, bytes 01, 13 00 A0 E3, cs=01^13^00^A0^E3=51:
//     one write, addr 0, wdata 0xE3A00013. load_done=1, cpu_hold=0.
//  2. N=3, three words 0x11111111/0x22222222/0x33333333, correct csum, rx_valid stuck high:
//     writes to addr 0,1,2 on consecutive word boundaries. words_loaded=3.
//  3. N=2 with csum byte off by one:
//     both words written, load_err=1, load_done=0, cpu_hold stays 1.
//  4. LEN byte 0x00, then a separate run with LEN 0x41 (65):
//     immediate ERR, no mem_we pulse, rx_ready=0 afterwards.
//  5. N=64 full image with random rx_valid gaps:
//     addresses 0..63, 64 writes, no wrap, each word's bytes land in the correct lanes.
//  6. Pulse rst_n low after 2 bytes of word 1, then pulse start during DATA of a fresh load:
//     reset clears state; the start pulse is ignored and the load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_pkg: shared types and sizes for the instruction-memory loader
package imem_pkg;
  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW = 6;
  localparam int IMEM_W = 32;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} ld_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte receive link plus instruction RAM write port
interface imem_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic mem_we;
  logic [imem_pkg::IMEM_AW-1:0] mem_addr;
  logic [imem_pkg::IMEM_W-1:0] mem_wdata;
  modport master(input rx_data, rx_valid, output rx_ready, mem_we, mem_addr, mem_wdata);
  modport slave(output rx_data, rx_valid, input rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams length/words/checksum bytes into the instruction RAM and gates the CPU
module imem_loader
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  imem_loader_if.master bus,
  output logic cpu_hold,
  output logic load_done,
  output logic load_err,
  output logic [IMEM_AW:0] words_loaded
);
  localparam logic [7:0] DEPTH8 = 8'(IMEM_DEPTH);
  ld_state_t state_q, state_d;
  logic [IMEM_AW:0] len_q, len_d, words_q, words_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] csum_q, csum_d;
  logic [23:0] lanes_q, lanes_d;
  logic we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [IMEM_W-1:0] wdata_q, wdata_d;
  logic take;
  assign bus.rx_ready = state_q inside {LEN, DATA, CSUM};
  assign take = bus.rx_valid && bus.rx_ready;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold = hold_q;
  assign load_done = done_q;
  assign load_err = err_q;
  assign words_loaded = words_q;
  // Next-state: header check, lane assembly, word commit and checksum verdict
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    words_d = words_q;
    byte_cnt_d = byte_cnt_q;
    csum_d = csum_q;
    lanes_d = lanes_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d = err_q;
    case (state_q)
      LEN: if (take) begin
        if (bus.rx_data == 8'd0 || bus.rx_data > DEPTH8) begin
          state_d = ERR;
          err_d = 1'b1;
        end else begin
          state_d = DATA;
          len_d = bus.rx_data[IMEM_AW:0];
          csum_d = bus.rx_data;
        end
      end
      DATA: if (take) begin
        csum_d = csum_q ^ bus.rx_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          we_d = 1'b1;
          wdata_d = {bus.rx_data, lanes_q};
          addr_d = words_q[IMEM_AW-1:0];
          words_d = words_q + 1'b1;
          state_d = (words_q + 1'b1 == len_q) ? CSUM : DATA;
        end else begin
          lanes_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
        end
      end
      CSUM: if (take) begin
        state_d = (bus.rx_data == csum_q) ? DONE : ERR;
        hold_d = bus.rx_data != csum_q;
        done_d = bus.rx_data == csum_q;
        err_d = bus.rx_data != csum_q;
      end
      default: if (start) begin
        state_d = LEN;
        words_d = '0;
        byte_cnt_d = '0;
        csum_d = '0;
        hold_d = 1'b1;
        done_d = 1'b0;
        err_d = 1'b0;
      end
    endcase
  end
  // State register; reset aborts any load and keeps the CPU held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      words_q <= '0;
      byte_cnt_q <= '0;
      csum_q <= '0;
      lanes_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      words_q <= words_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q <= csum_d;
      lanes_q <= lanes_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for the instruction-memory loader
module tb_imem_loader;
  import imem_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, load_done, load_err;
  logic [IMEM_AW:0] words_loaded;
  int n_cmp = 0;
  int n_bad = 0;
  logic [37:0] sb_q[$];
  logic [31:0] wbuf[64];
  imem_loader_if bus();
  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // Monitor: every RAM write must match the next expected {addr,data}
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h with empty scoreboard", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [37:0] e;
        e = sb_q.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(e[37:32]));
        chk("write_data", bus.mem_wdata, e[31:0]);
        chk("words_at_write", 32'(words_loaded), 32'(e[37:32]) + 1);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("rx_ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.rx_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic run_load(input int n, input logic [7:0] bad, input int gapmax);
    logic [7:0] cs;
    logic [31:0] w;
    pulse_start();
    cs = 8'(n);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      sb_q.push_back({6'(i), w});
      for (int k = 0; k < 4; k++) begin
        if (gapmax > 0) begin
          int g;
          g = $urandom_range(0, gapmax);
          if (g > 0) begin
            idle();
            tick(g);
          end
        end
        send_byte(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
    end
    send_byte(cs ^ bad);
    idle();
    tick(2);
  endtask
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    tick(2);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    rst_n = 1'b1;
    tick(1);
    // test 1: single word, checksum 0x51 hand-computed
    wbuf[0] = 32'hE3A00013;
    pulse_start();
    send_byte(8'h01);
    sb_q.push_back({6'd0, 32'hE3A00013});
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'hA0);
    send_byte(8'hE3);
    send_byte(8'h51);
    idle();
    tick(2);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_err", 32'(load_err), 32'd0);
    chk("t1_words", 32'(words_loaded), 32'd1);
    chk("t1_ready_done", 32'(bus.rx_ready), 32'd0);
    // test 2: three words, valid held high between bytes
    wbuf[0] = 32'h11111111;
    wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333;
    run_load(3, 8'h00, 0);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_words", 32'(words_loaded), 32'd3);
    // test 3: checksum off by one
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h01234567;
    run_load(2, 8'h01, 0);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_done", 32'(load_done), 32'd0);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    chk("t3_words", 32'(words_loaded), 32'd2);
    // test 4: bad length bytes 0x00 and 0x41
    pulse_start();
    send_byte(8'h00);
    chk("t4a_err", 32'(load_err), 32'd1);
    chk("t4a_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_data = 8'h04;
    tick(4);
    idle();
    chk("t4a_words", 32'(words_loaded), 32'd0);
    pulse_start();
    chk("t4b_err_cleared", 32'(load_err), 32'd0);
    send_byte(8'h41);
    chk("t4b_err", 32'(load_err), 32'd1);
    chk("t4b_ready", 32'(bus.rx_ready), 32'd0);
    chk("t4b_hold", 32'(cpu_hold), 32'd1);
    idle();
    tick(2);
    // test 5: full 64-word image with random valid gaps
    for (int i = 0; i < 64; i++) wbuf[i] = {8'(i) ^ 8'h5A, 8'(i), ~8'(i), 8'(i) + 8'h10};
    run_load(64, 8'h00, 2);
    chk("t5_done", 32'(load_done), 32'd1);
    chk("t5_words", 32'(words_loaded), 32'd64);
    // test 6: reset mid-load, then start pulse during DATA is ignored
    pulse_start();
    send_byte(8'h02);
    sb_q.push_back({6'd0, 32'hCAFEF00D});
    send_byte(8'h0D);
    send_byte(8'hF0);
    send_byte(8'hFE);
    send_byte(8'hCA);
    send_byte(8'h77);
    send_byte(8'h66);
    idle();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t6_rst_words", 32'(words_loaded), 32'd0);
    chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
    chk("t6_rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("t6_rst_done", 32'(load_done), 32'd0);
    pulse_start();
    send_byte(8'h01);
    sb_q.push_back({6'd0, 32'h44332211});
    send_byte(8'h11);
    send_byte(8'h22);
    idle();
    pulse_start();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    idle();
    tick(2);
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_hold", 32'(cpu_hold), 32'd0);
    chk("t6_words", 32'(words_loaded), 32'd1);
    tick(3);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
